pipe_hazard_ctrl: RTL and testbench

//  Hazard/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB) in Top.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 57 +++++
 rtl/fwd_select.sv | 49 ++++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard/flush sequencer.
//   state_t            : sequencer state (RUN / STALL)
//   FWD_RF/MEM/WB      : EX operand source encodings for fwd_a / fwd_b
//   REG_ZERO           : hard-wired zero register, never a hazard source
//   WAIT_EX / WAIT_MEM : stall lengths for a producer in EX / MEM when
//                        forwarding is not built in
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int unsigned REG_ZERO = 0;

   localparam int unsigned WAIT_EX  = 2;
   localparam int unsigned WAIT_MEM = 1;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the hazard-unit view of the pipeline: ID source registers, the
// destination/write flags of EX/MEM/WB, the EX branch outcome, and the
// control outputs back to the pipeline (PC/IF-ID enables, flush, bubble,
// forwarding selects, event counters).
//   master : pipeline side (drives stage info, receives control)
//   slave  : hazard controller side
// Parameters: REG_AW register-address width, CNT_W counter width.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);

   // stage information
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_regwr;
   logic              ex_memrd;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_regwr;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_regwr;
   logic              ex_br_valid;
   logic              ex_br_taken;

   // control back to the pipeline
   logic              pc_we;
   logic              ifid_we;
   logic              ifid_flush;
   logic              idex_bubble;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [CNT_W-1:0]  stall_cycles;
   logic [CNT_W-1:0]  flush_events;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt,
             ex_rd, ex_regwr, ex_memrd, mem_rd, mem_regwr, wb_rd, wb_regwr,
             ex_br_valid, ex_br_taken,
      input  pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b,
             stall_cycles, flush_events
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt,
             ex_rd, ex_regwr, ex_memrd, mem_rd, mem_regwr, wb_rd, wb_regwr,
             ex_br_valid, ex_br_taken,
      output pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b,
             stall_cycles, flush_events
   );

endinterface : pipe_hazard_ctrl_if

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Match/priority logic for one ID-stage source operand.
//   src, use_src          : source register and whether it is actually read
//   ex_rd/ex_regwr        : EX-stage producer
//   mem_rd/mem_regwr      : MEM-stage producer
//   wb_rd/wb_regwr        : WB-stage producer
//   sel                   : operand source (MEM beats WB; FWD_RF if FWD_ON=0)
//   ex_hit, mem_hit       : raw match flags used by the stall logic
// -----------------------------------------------------------------------------
module fwd_select
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter bit FWD_ON = 1'b0
) (
   input  logic [REG_AW-1:0] src,
   input  logic              use_src,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwr,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwr,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwr,
   output logic [1:0]        sel,
   output logic              ex_hit,
   output logic              mem_hit
);

   logic live;
   logic wb_hit;

   // $0 is hard-wired, so reading it can never depend on an older write
   assign live    = use_src && (src != REG_AW'(REG_ZERO));
   assign ex_hit  = live && ex_regwr  && (ex_rd  == src);
   assign mem_hit = live && mem_regwr && (mem_rd == src);
   assign wb_hit  = live && wb_regwr  && (wb_rd  == src);

   // NOTE: give every always_comb output a default first so no path holds a value (no latch).
   always_comb begin
      sel = FWD_RF;
      if (FWD_ON) begin
         // the MEM copy is younger than the WB copy of the same register
         if (mem_hit)     sel = FWD_MEM;
         else if (wb_hit) sel = FWD_WB;
      end
   end

endmodule : fwd_select

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   - stalls PC and IF/ID and injects ID/EX bubbles on RAW / load-use hazards
//   - flushes the wrong-path fetch when EX resolves a taken branch
//   - selects EX operand forwarding sources
//   - keeps saturating stall / flush event counters
// Ports:
//   clk    : pipeline clock
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_hazard_ctrl_if.slave (stage info in, control out)
// Build option (macro FWD_EN):
//   defined   : forwarding on; only a load in EX hazards (single bubble)
//   undefined : forwarding off (fwd tied 00); EX producer stalls 2 cycles,
//               MEM producer 1 cycle; WB needs none (write-before-read RF)
// Control outputs are Mealy (state + current inputs); state and counters
// change on posedge clk.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   pipe_hazard_ctrl_if.slave   bus
);

`ifdef FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   state_t           state;
   logic [1:0]       wait_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic [1:0] sel_a, sel_b;
   logic       a_ex, a_mem, b_ex, b_mem;
   logic       taken;
   logic       hazard;
   logic       go_stall;
   logic       stall_now;

   fwd_select #(.REG_AW(REG_AW), .FWD_ON(FWD_ON)) u_fwd_a (
      .src       (bus.id_rs),
      .use_src   (bus.id_use_rs),
      .ex_rd     (bus.ex_rd),
      .ex_regwr  (bus.ex_regwr),
      .mem_rd    (bus.mem_rd),
      .mem_regwr (bus.mem_regwr),
      .wb_rd     (bus.wb_rd),
      .wb_regwr  (bus.wb_regwr),
      .sel       (sel_a),
      .ex_hit    (a_ex),
      .mem_hit   (a_mem)
   );

   fwd_select #(.REG_AW(REG_AW), .FWD_ON(FWD_ON)) u_fwd_b (
      .src       (bus.id_rt),
      .use_src   (bus.id_use_rt),
      .ex_rd     (bus.ex_rd),
      .ex_regwr  (bus.ex_regwr),
      .mem_rd    (bus.mem_rd),
      .mem_regwr (bus.mem_regwr),
      .wb_rd     (bus.wb_rd),
      .wb_regwr  (bus.wb_regwr),
      .sel       (sel_b),
      .ex_hit    (b_ex),
      .mem_hit   (b_mem)
   );

   assign taken = bus.ex_br_valid && bus.ex_br_taken;

`ifdef FWD_EN
   // only a load result is still unavailable to forwarding: one bubble
   assign hazard   = bus.ex_memrd && (a_ex || b_ex);
   assign go_stall = 1'b0;
`else
   // EX producer needs two cycles (enter STALL), MEM producer needs one
   assign hazard   = a_ex || b_ex || a_mem || b_mem;
   assign go_stall = a_ex || b_ex;
`endif

   // a taken branch kills the ID instruction, so its hazards are irrelevant
   assign stall_now = !taken && ((state == STALL) || hazard);

   // reset is folded in combinationally so the pipeline sees a quiet,
   // flushing controller in the very cycle rst_n drops
   always_comb begin
      bus.pc_we       = 1'b1;
      bus.ifid_we     = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_bubble = 1'b0;
      bus.fwd_a       = sel_a;
      bus.fwd_b       = sel_b;
      if (!rst_n) begin
         bus.pc_we       = 1'b0;
         bus.ifid_we     = 1'b0;
         bus.ifid_flush  = 1'b1;
         bus.idex_bubble = 1'b1;
         bus.fwd_a       = FWD_RF;
         bus.fwd_b       = FWD_RF;
      end else if (taken) begin
         bus.ifid_flush  = 1'b1;
         bus.idex_bubble = 1'b1;
      end else if (stall_now) begin
         bus.pc_we       = 1'b0;
         bus.ifid_we     = 1'b0;
         bus.idex_bubble = 1'b1;
      end
   end

   assign bus.stall_cycles = stall_cnt;
   assign bus.flush_events = flush_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (taken) begin
         // also abandons any stall in progress
         state    <= RUN;
         wait_cnt <= '0;
         if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else if (state == STALL) begin
         if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         wait_cnt <= wait_cnt - 1'b1;
         if (wait_cnt == 2'd1) state <= RUN;
      end else if (hazard) begin
         if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (go_stall) begin
            wait_cnt <= 2'(WAIT_EX - 1);
            state    <= STALL;
         end
      end
   end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. Counters are built 4 bits wide so
// saturation is reachable in a few cycles. Honours FWD_EN the same way the
// design does. Inputs change on the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference model helpers ----------------
   function automatic bit hit(input int src, input bit use_src, input bit wr, input int rd);
      return (src != 0) && use_src && wr && (rd == src);
   endfunction

   // cycles the ID instruction must wait given the current stage contents
   function automatic int need_wait();
      bit ex_any, mem_any;
      ex_any  = hit(bus.id_rs, bus.id_use_rs, bus.ex_regwr, bus.ex_rd) ||
                hit(bus.id_rt, bus.id_use_rt, bus.ex_regwr, bus.ex_rd);
      mem_any = hit(bus.id_rs, bus.id_use_rs, bus.mem_regwr, bus.mem_rd) ||
                hit(bus.id_rt, bus.id_use_rt, bus.mem_regwr, bus.mem_rd);
`ifdef FWD_EN
      return (bus.ex_memrd && ex_any) ? 1 : 0;
`else
      if (ex_any) return 2;
      return mem_any ? 1 : 0;
`endif
   endfunction

   function automatic logic [1:0] exp_fwd(input int src, input bit use_src);
`ifdef FWD_EN
      if (hit(src, use_src, bus.mem_regwr, bus.mem_rd)) return 2'b01;
      if (hit(src, use_src, bus.wb_regwr, bus.wb_rd))   return 2'b10;
`endif
      return 2'b00;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_idle();
      bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
      bus.ex_rd = '0; bus.ex_regwr = 1'b0; bus.ex_memrd = 1'b0;
      bus.mem_rd = '0; bus.mem_regwr = 1'b0;
      bus.wb_rd = '0; bus.wb_regwr = 1'b0;
      bus.ex_br_valid = 1'b0; bus.ex_br_taken = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_idle();
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_idle();
      bus.id_rs = 5'd3; bus.id_use_rs = 1'b1; bus.mem_rd = 5'd3; bus.mem_regwr = 1'b1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble} !== 4'b0011) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 0011", {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble});
      end
      vectors++;
      if ({bus.fwd_a, bus.fwd_b} !== 4'b0000 || bus.stall_cycles !== '0 || bus.flush_events !== '0) begin
         miscompares++;
         $display("FAIL reset_fwd_cnt: fwd %b%b stall %0d flush %0d want 0", bus.fwd_a, bus.fwd_b,
                  bus.stall_cycles, bus.flush_events);
      end
   endtask

`ifdef FWD_EN
   // add in MEM feeding ID: forwarded, never stalled
   task automatic test_forward();
      do_reset();
      @(negedge clk);
      bus.id_rs = 5'd21; bus.id_use_rs = 1'b1; bus.id_rt = 5'd22; bus.id_use_rt = 1'b1;
      bus.mem_rd = 5'd21; bus.mem_regwr = 1'b1; bus.wb_rd = 5'd21; bus.wb_regwr = 1'b1;
      #1;
      vectors++;
      if (bus.fwd_a !== 2'b01 || bus.pc_we !== 1'b1 || bus.fwd_b !== 2'b00) begin
         miscompares++;
         $display("FAIL t1_fwd: fwd_a %b fwd_b %b pc_we %b want 01 00 1", bus.fwd_a, bus.fwd_b, bus.pc_we);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (bus.stall_cycles !== 4'd0) begin
         miscompares++;
         $display("FAIL t1_cnt: stall_cycles %0d want 0", bus.stall_cycles);
      end
   endtask

   // load in EX feeding ID: exactly one bubble
   task automatic test_load_use();
      do_reset();
      @(negedge clk);
      bus.id_rs = 5'd21; bus.id_use_rs = 1'b1;
      bus.ex_rd = 5'd21; bus.ex_regwr = 1'b1; bus.ex_memrd = 1'b1;
      #1;
      vectors++;
      if (bus.pc_we !== 1'b0 || bus.idex_bubble !== 1'b1) begin
         miscompares++;
         $display("FAIL t2_bubble: pc_we %b bubble %b want 0 1", bus.pc_we, bus.idex_bubble);
      end
      @(negedge clk);
      bus.ex_regwr = 1'b0; bus.ex_memrd = 1'b0; bus.mem_rd = 5'd21; bus.mem_regwr = 1'b1;
      #1;
      vectors++;
      if (bus.pc_we !== 1'b1 || bus.fwd_a !== 2'b01 || bus.stall_cycles !== 4'd1) begin
         miscompares++;
         $display("FAIL t2_resume: pc_we %b fwd_a %b stall %0d want 1 01 1", bus.pc_we, bus.fwd_a,
                  bus.stall_cycles);
      end
   endtask
`else
   // add in EX feeding ID without forwarding: two stall cycles
   task automatic test_ex_stall();
      do_reset();
      @(negedge clk);
      bus.id_rs = 5'd21; bus.id_use_rs = 1'b1; bus.id_rt = 5'd22; bus.id_use_rt = 1'b1;
      bus.ex_rd = 5'd22; bus.ex_regwr = 1'b1;
      #1;
      vectors++;
      if ({bus.pc_we, bus.ifid_we, bus.idex_bubble} !== 3'b001) begin
         miscompares++;
         $display("FAIL t3_stall1: pc/ifid/bubble %b want 001", {bus.pc_we, bus.ifid_we, bus.idex_bubble});
      end
      @(negedge clk);
      bus.ex_regwr = 1'b0; bus.mem_rd = 5'd22; bus.mem_regwr = 1'b1;
      #1;
      vectors++;
      if ({bus.pc_we, bus.ifid_we, bus.idex_bubble} !== 3'b001) begin
         miscompares++;
         $display("FAIL t3_stall2: pc/ifid/bubble %b want 001", {bus.pc_we, bus.ifid_we, bus.idex_bubble});
      end
      @(negedge clk);
      bus.mem_regwr = 1'b0; bus.wb_rd = 5'd22; bus.wb_regwr = 1'b1;
      #1;
      vectors++;
      if (bus.pc_we !== 1'b1 || bus.idex_bubble !== 1'b0 || bus.stall_cycles !== 4'd2 || bus.fwd_b !== 2'b00) begin
         miscompares++;
         $display("FAIL t3_resume: pc_we %b bubble %b stall %0d fwd_b %b want 1 0 2 00", bus.pc_we,
                  bus.idex_bubble, bus.stall_cycles, bus.fwd_b);
      end
   endtask
`endif

   task automatic test_branch_taken();
      do_reset();
      @(negedge clk);
      bus.id_rs = 5'd9; bus.id_use_rs = 1'b1;
      bus.ex_rd = 5'd9; bus.ex_regwr = 1'b1; bus.ex_memrd = 1'b1;
      bus.ex_br_valid = 1'b1; bus.ex_br_taken = 1'b1;
      #1;
      vectors++;
      if ({bus.pc_we, bus.ifid_flush, bus.idex_bubble} !== 3'b111) begin
         miscompares++;
         $display("FAIL t4_flush: pc/flush/bubble %b want 111", {bus.pc_we, bus.ifid_flush, bus.idex_bubble});
      end
      @(negedge clk);
      set_idle();
      #1;
      vectors++;
      if (bus.flush_events !== 4'd1 || bus.stall_cycles !== 4'd0 || bus.pc_we !== 1'b1) begin
         miscompares++;
         $display("FAIL t4_cnt: flush %0d stall %0d pc_we %b want 1 0 1", bus.flush_events,
                  bus.stall_cycles, bus.pc_we);
      end
   endtask

   task automatic test_branch_not_taken();
      do_reset();
      @(negedge clk);
      bus.id_rs = 5'd23; bus.id_use_rs = 1'b1; bus.ex_rd = 5'd7; bus.ex_regwr = 1'b1;
      bus.ex_br_valid = 1'b1; bus.ex_br_taken = 1'b0;
      #1;
      vectors++;
      if ({bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble} !== 4'b1100) begin
         miscompares++;
         $display("FAIL t5_run: ctrl %b want 1100", {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble});
      end
      @(negedge clk);
      set_idle();
      #1;
      vectors++;
      if (bus.flush_events !== 4'd0 || bus.stall_cycles !== 4'd0) begin
         miscompares++;
         $display("FAIL t5_cnt: flush %0d stall %0d want 0 0", bus.flush_events, bus.stall_cycles);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      @(negedge clk);
      bus.id_rs = 5'd4; bus.id_use_rs = 1'b1;
      bus.ex_rd = 5'd4; bus.ex_regwr = 1'b1; bus.ex_memrd = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble} !== 4'b0011 || bus.stall_cycles !== 4'd0) begin
         miscompares++;
         $display("FAIL t6_reset: ctrl %b stall %0d want 0011 0",
                  {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble}, bus.stall_cycles);
      end
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if (bus.pc_we !== 1'b1 || bus.stall_cycles !== 4'd0 || bus.flush_events !== 4'd0) begin
         miscompares++;
         $display("FAIL t6_release: pc_we %b stall %0d flush %0d want 1 0 0", bus.pc_we,
                  bus.stall_cycles, bus.flush_events);
      end
      // writes to $0 never create a dependency
      bus.id_rs = 5'd0; bus.id_use_rs = 1'b1; bus.id_rt = 5'd0; bus.id_use_rt = 1'b1;
      bus.ex_rd = 5'd0; bus.ex_regwr = 1'b1; bus.ex_memrd = 1'b1;
      bus.mem_rd = 5'd0; bus.mem_regwr = 1'b1;
      #1;
      vectors++;
      if (bus.pc_we !== 1'b1 || bus.idex_bubble !== 1'b0 || bus.fwd_a !== 2'b00) begin
         miscompares++;
         $display("FAIL t6_zero: pc_we %b bubble %b fwd_a %b want 1 0 00", bus.pc_we, bus.idex_bubble, bus.fwd_a);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      @(negedge clk);
      bus.id_rs = 5'd12; bus.id_use_rs = 1'b1;
      bus.ex_rd = 5'd12; bus.ex_regwr = 1'b1; bus.ex_memrd = 1'b1;
      repeat (CMAX + 5) @(negedge clk);
      bus.ex_br_valid = 1'b1; bus.ex_br_taken = 1'b1;
      repeat (CMAX + 5) @(negedge clk);
      #1;
      vectors++;
      if (bus.stall_cycles !== 4'(CMAX) || bus.flush_events !== 4'(CMAX)) begin
         miscompares++;
         $display("FAIL sat: stall %0d flush %0d want %0d %0d", bus.stall_cycles, bus.flush_events, CMAX, CMAX);
      end
   endtask

   // random traffic against a cycle-count model of the hazard rules
   task automatic test_random();
      int pend = 0;
      int e_stall = 0;
      int e_flush = 0;
      bit taken, stalled;
      int nw;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         bus.id_rs = 5'($urandom_range(0, 3));  bus.id_use_rs = 1'($urandom);
         bus.id_rt = 5'($urandom_range(0, 3));  bus.id_use_rt = 1'($urandom);
         bus.ex_rd = 5'($urandom_range(0, 3));  bus.ex_regwr = 1'($urandom); bus.ex_memrd = 1'($urandom);
         bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_regwr = 1'($urandom);
         bus.wb_rd = 5'($urandom_range(0, 3));  bus.wb_regwr = 1'($urandom);
         bus.ex_br_valid = ($urandom_range(0, 5) == 0);
         bus.ex_br_taken = 1'($urandom);
         #1;
         taken   = bus.ex_br_valid && bus.ex_br_taken;
         nw      = need_wait();
         stalled = !taken && (pend > 0 || nw > 0);
         vectors++;
         if (bus.pc_we !== !stalled || bus.idex_bubble !== (taken || stalled) || bus.ifid_flush !== taken) begin
            miscompares++;
            $display("FAIL rnd_ctrl[%0d]: pc %b bub %b flush %b want %b %b %b", i, bus.pc_we, bus.idex_bubble,
                     bus.ifid_flush, !stalled, taken || stalled, taken);
         end
         if (!taken) begin
            vectors++;
            if (bus.ifid_we !== !stalled) begin
               miscompares++;
               $display("FAIL rnd_ifid[%0d]: got %b want %b", i, bus.ifid_we, !stalled);
            end
         end
         vectors++;
         if (bus.fwd_a !== exp_fwd(bus.id_rs, bus.id_use_rs) || bus.fwd_b !== exp_fwd(bus.id_rt, bus.id_use_rt)) begin
            miscompares++;
            $display("FAIL rnd_fwd[%0d]: got %b %b want %b %b", i, bus.fwd_a, bus.fwd_b,
                     exp_fwd(bus.id_rs, bus.id_use_rs), exp_fwd(bus.id_rt, bus.id_use_rt));
         end
         vectors++;
         if (bus.stall_cycles !== 4'(e_stall) || bus.flush_events !== 4'(e_flush)) begin
            miscompares++;
            $display("FAIL rnd_cnt[%0d]: stall %0d flush %0d want %0d %0d", i, bus.stall_cycles,
                     bus.flush_events, e_stall, e_flush);
         end
         if (taken) begin
            pend = 0;
            if (e_flush < CMAX) e_flush++;
         end else if (pend > 0) begin
            pend--;
            if (e_stall < CMAX) e_stall++;
         end else if (nw > 0) begin
            pend = nw - 1;
            if (e_stall < CMAX) e_stall++;
         end
      end
   endtask

   initial begin
      test_reset();
`ifdef FWD_EN
      test_forward();
      test_load_use();
`else
      test_ex_stall();
`endif
      test_branch_taken();
      test_branch_not_taken();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
